// File: rtl/jk_pkg.sv
// Shared types and the JK next-state rule for the command sequencer and its benches.
package jk_pkg;

  localparam int JK_LEN_W = 4;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    RST  = 2'b01,
    SET  = 2'b10,
    TOG  = 2'b11
  } jk_op_t;

  typedef struct packed {
    jk_op_t              op;
    logic [JK_LEN_W-1:0] len;
  } jk_cmd_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRIVE = 1'b1
  } jk_state_t;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic r;
    case ({j, k})
      2'b00:   r = q;
      2'b01:   r = 1'b0;
      2'b10:   r = 1'b1;
      default: r = ~q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous FIFO with full/empty; a push while full is dropped even on a pop edge.
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rd_dat  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wr_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Replays queued hold/reset/set/toggle commands on registered j/k for len+1 cycles each.
// Optional q checker enabled by macro JK_SEQ_CHECK_EN.
module jk_cmd_sequencer
  import jk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = JK_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             j,
  output logic             k,
  output logic             busy,
  input  logic             q,
  output logic             mismatch,
  output logic [7:0]       err_cnt
);

  localparam int CW = 2 + LEN_W;

  jk_state_t        r_state;
  jk_state_t        w_state_nxt;
  logic             r_j;
  logic             r_k;
  logic [LEN_W-1:0] r_remain;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CW-1:0]    w_head;
  jk_op_t           w_head_op;
  logic [LEN_W-1:0] w_head_len;
  logic             w_pop;
  logic             w_j_ld;
  logic             w_k_ld;

  assign cmd_ready  = !w_fifo_full;
  assign w_head_op  = jk_op_t'(w_head[LEN_W +: 2]);
  assign w_head_len = w_head[LEN_W-1:0];

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (cmd_valid && cmd_ready),
    .i_wr_dat ({cmd_op, cmd_len}),
    .i_pop    (w_pop),
    .o_rd_dat (w_head),
    .o_full   (w_fifo_full),
    .o_empty  (w_fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_fifo_empty) w_state_nxt = S_DRIVE;
      S_DRIVE: if ((r_remain == '0) && w_fifo_empty) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Popping on the last drive cycle keeps consecutive commands gapless.
  always_comb begin
    w_pop  = 1'b0;
    w_j_ld = 1'b0;
    w_k_ld = 1'b0;
    case (r_state)
      S_IDLE:  w_pop = !w_fifo_empty;
      S_DRIVE: w_pop = !w_fifo_empty && (r_remain == '0);
      default: w_pop = 1'b0;
    endcase
    case (w_head_op)
      RST: w_k_ld = 1'b1;
      SET: w_j_ld = 1'b1;
      TOG: begin
        w_j_ld = 1'b1;
        w_k_ld = 1'b1;
      end
      default: begin
        w_j_ld = 1'b0;
        w_k_ld = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_j      <= 1'b0;
      r_k      <= 1'b0;
      r_remain <= '0;
    end else if (w_pop) begin
      r_j      <= w_j_ld;
      r_k      <= w_k_ld;
      r_remain <= w_head_len;
    end else if (r_state == S_DRIVE) begin
      if (r_remain != '0) begin
        r_remain <= r_remain - 1'b1;
      end else begin
        r_j <= 1'b0;
        r_k <= 1'b0;
      end
    end
  end

  assign j    = r_j;
  assign k    = r_k;
  assign busy = !w_fifo_empty || (r_state == S_DRIVE);

`ifdef JK_SEQ_CHECK_EN
  logic       r_exp_q;
  logic       r_exp_vld;
  logic       r_mismatch;
  logic [7:0] r_err_cnt;

  // The model becomes trustworthy only once a set or reset cycle pins q down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exp_q    <= 1'b0;
      r_exp_vld  <= 1'b0;
      r_mismatch <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_exp_q <= jk_next(r_exp_q, r_j, r_k);
      if (r_j != r_k) r_exp_vld <= 1'b1;
      if (r_exp_vld && (q != r_exp_q)) begin
        r_mismatch <= 1'b1;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign mismatch = r_mismatch;
  assign err_cnt  = r_err_cnt;
`else
  logic w_q_unused;
  assign w_q_unused = q;
  assign mismatch   = 1'b0;
  assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed and randomized checks of jk_cmd_sequencer against a command-stream reference model.
module tb_jk_cmd_sequencer;
  import jk_pkg::*;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_len;
  logic       j;
  logic       k;
  logic       busy;
  logic       q;
  logic       mismatch;
  logic [7:0] err_cnt;

  logic       q_mdl;
  logic       q_force_en;
  logic       q_force_val;

  int         n_vec = 0;
  int         n_err = 0;
  jk_cmd_t    burst[$];
  logic       q_log[$];
  logic       b2b_q[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0] ff_op[5];

  jk_cmd_sequencer #(
    .DEPTH (4),
    .LEN_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .q         (q),
    .mismatch  (mismatch),
    .err_cnt   (err_cnt)
  );

  // Stand-in for the downstream JKFF stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_mdl <= 1'b0;
    else     q_mdl <= jk_next(q_mdl, j, k);
  end
  assign q = q_force_en ? q_force_val : q_mdl;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds every command in burst with valid held high; expects one j/k entry per duration
  // cycle, contiguous from the edge after the first accept, then idle.
  task automatic run_burst(input string tag);
    logic [1:0] exp_jk[$];
    int         fed = 0;
    int         pos = 0;
    int         budget = 0;
    bit         started = 0;
    bit         acc;
    q_log.delete();
    foreach (burst[i])
      for (int c = 0; c <= int'(burst[i].len); c++) exp_jk.push_back(burst[i].op);
    while (pos <= exp_jk.size() && budget < 2000) begin
      if (fed < burst.size()) begin
        cmd_valid = 1'b1;
        cmd_op    = burst[fed].op;
        cmd_len   = burst[fed].len;
      end else begin
        cmd_valid = 1'b0;
      end
      acc = cmd_valid && cmd_ready;
      tick();
      budget++;
      if (started) begin
        q_log.push_back(q);
        if (pos < exp_jk.size()) begin
          chk({tag, "_jk"}, {j, k}, exp_jk[pos]);
        end else begin
          chk({tag, "_end_jk"}, {j, k}, 2'b00);
          chk({tag, "_end_busy"}, busy, 1'b0);
        end
        pos++;
      end
      if (acc) begin
        fed++;
        started = 1;
      end
    end
    cmd_valid = 1'b0;
    chk({tag, "_accepted"}, fed, burst.size());
    chk({tag, "_cycles"}, pos, exp_jk.size() + 1);
  endtask

  initial begin
    jk_cmd_t c;
    int      accepted;
    int      fi;
    bit      acc;

    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = 4'd0;
    q_force_en = 1'b0; q_force_val = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_jk", {j, k}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mismatch", mismatch, 1'b0);
    chk("rst_err_cnt", err_cnt, 8'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset in the third drive cycle of a SET len 5
    cmd_valid = 1'b1; cmd_op = SET; cmd_len = 4'd5;
    tick();
    cmd_valid = 1'b0;
    chk("midrst_busy_rise", busy, 1'b1);
    tick();
    chk("midrst_drive1", {j, k}, 2'b10);
    tick(); tick();
    chk("midrst_drive3", {j, k}, 2'b10);
    rst = 1'b1;
    #1;
    chk("midrst_jk", {j, k}, 2'b00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", cmd_ready, 1'b1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("midrst_after_jk", {j, k}, 2'b00);
      chk("midrst_after_busy", busy, 1'b0);
    end

    // Single one-cycle SET
    cmd_valid = 1'b1; cmd_op = SET; cmd_len = 4'd0;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("single_jk", {j, k}, 2'b10);
    tick();
    chk("single_end_jk", {j, k}, 2'b00);
    chk("single_end_busy", busy, 1'b0);

    // Back-to-back RST1, SET1, TOG3 and the resulting flip-flop output
    burst.delete();
    c.op = RST; c.len = 4'd1; burst.push_back(c);
    c.op = SET; c.len = 4'd1; burst.push_back(c);
    c.op = TOG; c.len = 4'd3; burst.push_back(c);
    run_burst("b2b");
    for (int i = 0; i < 8; i++) chk("b2b_q", q_log[i+1], b2b_q[i]);

    // Maximum duration
    burst.delete();
    c.op = TOG; c.len = 4'd15; burst.push_back(c);
    run_burst("maxlen");

    // Fill the FIFO behind a 10-cycle SET, then drain
    for (int i = 0; i < 5; i++) ff_op[i] = 2'($urandom_range(1, 3));
    cmd_valid = 1'b1; cmd_op = SET; cmd_len = 4'd9;
    tick();
    accepted = 1;
    fi = 0;
    for (int i = 1; i <= 10; i++) begin
      cmd_op = ff_op[fi]; cmd_len = 4'd0;
      chk("full_ready", cmd_ready, (i <= 4) ? 1'b1 : 1'b0);
      acc = cmd_ready;
      tick();
      if (acc) begin
        accepted++;
        fi++;
      end
    end
    chk("full_accepted", accepted, 5);
    chk("full_ready_low", cmd_ready, 1'b0);
    chk("full_jk_last", {j, k}, 2'b10);
    tick();
    chk("full_ready_after_pop", cmd_ready, 1'b1);
    chk("full_jk_b", {j, k}, ff_op[0]);
    cmd_op = ff_op[fi];
    tick();
    cmd_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      chk("full_jk_stream", {j, k}, ff_op[i]);
      tick();
    end
    chk("full_end_jk", {j, k}, 2'b00);
    chk("full_end_busy", busy, 1'b0);

    // Randomized bursts with idle gaps
    for (int b = 0; b < 12; b++) begin
      burst.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
        c.op  = jk_op_t'($urandom_range(0, 3));
        c.len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
        burst.push_back(c);
      end
      run_burst("rand");
      for (int g = 0; g < int'($urandom_range(0, 4)); g++) begin
        tick();
        chk("rand_gap_jk", {j, k}, 2'b00);
      end
    end

`ifdef JK_SEQ_CHECK_EN
    // SET then HOLD 2 with q forced low in the second hold cycle
    rst = 1'b1; #1; rst = 1'b0;
    cmd_valid = 1'b1; cmd_op = SET; cmd_len = 4'd0;
    tick();
    cmd_op = HOLD; cmd_len = 4'd2;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("chk_err_before", err_cnt, 8'd0);
    q_force_en = 1'b1; q_force_val = 1'b0;
    tick();
    q_force_en = 1'b0;
    chk("chk_mismatch", mismatch, 1'b1);
    chk("chk_err_cnt", err_cnt, 8'd1);
    repeat (5) tick();
    chk("chk_sticky", mismatch, 1'b1);
    chk("chk_err_hold", err_cnt, 8'd1);
    rst = 1'b1; #1;
    chk("chk_rst_mismatch", mismatch, 1'b0);
    chk("chk_rst_err", err_cnt, 8'd0);
    tick();
    rst = 1'b0;
    tick();
`endif

    chk("final_mismatch", mismatch, 1'b0);
    chk("final_err_cnt", err_cnt, 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jk_cmd_sequencer.md
# jk_cmd_sequencer

Upstream driver for the `JKFF` flip-flop stage. It accepts queued high-level flip-flop commands (hold, reset, set, toggle), each with a duration, over a valid/ready handshake. It replays each command on the registered `j`/`k` outputs for the requested number of clock cycles. An optional checker models the expected `q` and flags disagreement with the `q` returned by the flip-flop.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries; power of two, 2 to 16.
- `LEN_W`, 4: width of the duration field.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept; equals `!full`.
- `cmd_op`  in  2  operation: 00 hold, 01 reset (j=0,k=1), 10 set (j=1,k=0), 11 toggle (j=1,k=1).
- `cmd_len`  in  LEN_W  drive duration minus one; the command lasts `cmd_len+1` cycles.
- `j`  out  1  registered J drive to `JKFF`.
- `k`  out  1  registered K drive to `JKFF`.
- `busy`  out  1  FIFO non-empty or a command is being driven.
- `q`  in  1  flip-flop output fed back; used only by the checker.
- `mismatch`  out  1  sticky checker error flag.
- `err_cnt`  out  8  saturating count of mismatching cycles.

## Operation
- Transfer occurs on any edge where `cmd_valid && cmd_ready`; `{cmd_op, cmd_len}` is written to the FIFO.
- A push while full is refused, even if a pop happens on the same edge. `cmd_ready` is computed from the current occupancy only.
- FSM states:
  - IDLE: `j=k=0`, `remain` = 0.
  - DRIVE: `j`/`k` hold the current op; `remain` counts down.
- IDLE to DRIVE: on an edge where the FIFO is non-empty, pop the head, load `j`/`k` from the op and load `remain = cmd_len`.
- In DRIVE with `remain != 0`, decrement `remain`.
- In DRIVE with `remain == 0`:
  - FIFO non-empty: pop the next command immediately, with no bubble cycle.
  - FIFO empty: go to IDLE and set `j=k=0`.
- `cmd_len = 0` yields exactly one cycle of drive. The maximum, `2^LEN_W - 1`, yields `2^LEN_W` cycles; `remain` never wraps.
- Hold commands (op 00) occupy their full duration like any other op.
- Reset, including mid-command: FIFO emptied, `remain` = 0, state IDLE, `j=k=0`, `mismatch=0`, `err_cnt=0`, checker model invalidated.

## Timing
- Reset values: `cmd_ready=1`, `j=0`, `k=0`, `busy=0`, `mismatch=0`, `err_cnt=0`.
- A command accepted at edge T while idle with an empty FIFO drives `j`/`k` starting at edge T+1. It occupies edges T+1 through T+1+`cmd_len`.
- `busy` rises at edge T and falls at the edge where `j`/`k` return to 0.
- Back-to-back commands are contiguous: the last cycle of command N is followed directly by the first cycle of command N+1.
- `cmd_ready` deasserts at the edge where occupancy reaches `DEPTH`. It reasserts at the edge after a pop.

## Configuration
Macro: `JK_SEQ_CHECK_EN`.
- Defined:
  - Model register `exp_q` and flag `exp_vld`, both cleared by reset. At each edge the model applies the JK rule to the current `j`/`k`.
  - `exp_vld` is set by the first set or reset cycle; hold and toggle cycles on an unknown state leave it clear.
  - On each edge where `exp_vld` was already set, compare `q` against `exp_q`. On a difference, set `mismatch` and increment `err_cnt`, saturating at 255.
- Not defined: no model logic; `mismatch` and `err_cnt` are tied to 0 and `q` is unused.

## Structure
- Shared package `jk_pkg`:
  - enum `jk_op_t` (HOLD, RST, SET, TOG);
  - struct `jk_cmd_t` {op, len};
  - function `jk_next(q, j, k)`, used by both the checker and the testbenches.
- Sub-module `jk_cmd_fifo`: synchronous FIFO with full/empty, parameterised by `DEPTH` and width.
- The FSM, the counter and the optional checker stay in the top module.

## Test plan
- Reset mid-command: push {SET, len 5} and assert `rst` at the third drive cycle → `j=k=0`, `busy=0` and `cmd_ready=1` immediately; no further drive after release.
- Single command: accept {SET, len 0} at edge T → `j=1,k=0` for exactly one cycle from T+1; `j=k=0` and `busy=0` at T+2.
- Back-to-back sequence: {RST, 1}, {SET, 1}, {TOG, 3} → `j`/`k` = 01,01,10,10,11,11,11,11 then 00 with no gaps; `q` from `JKFF` reads 0,0,1,1,0,1,0,1.
- Full FIFO (DEPTH 4): hold `cmd_valid` high with 6 commands while one command is driving → exactly 5 accepted before the first pop; `cmd_ready` low while full; a push on a pop edge is refused.
- Max length: {TOG, len 15} → 16 toggle cycles, then IDLE; no wrap of `remain`.
- Checker (`JK_SEQ_CHECK_EN` defined): drive {SET, 0} then {HOLD, 2}, and force `q=0` in the second hold cycle → `mismatch=1`, `err_cnt=1`. The sticky flag persists until `rst`.
